// File: rtl/lift_pkg.sv
// Shared lift encodings: motor direction codes and scheduler states.
// The lift motion FSM decodes the same direction values.
package lift_pkg;

  localparam int N_FLOORS_DEF = 4;

  typedef enum logic [1:0] {
    UP   = 2'b00,
    DOWN = 2'b01,
    STAY = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MOVE_UP = 2'b01,
    MOVE_DN = 2'b10,
    DOOR    = 2'b11
  } state_e;

  function automatic logic [1:0] dirFor(state_e s);
    case (s)
      MOVE_UP: return UP;
      MOVE_DN: return DOWN;
      default: return STAY;
    endcase
  endfunction

endpackage

// File: rtl/lift_door_timer.sv
// Door dwell counter: loads CYCLES-1, counts down to zero while enabled,
// and flags done while enabled at zero.
module lift_door_timer #(
  parameter int  CYCLES = 8,
  localparam int W      = $clog2(CYCLES)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/lift_call_scheduler.sv
// Single-car SCAN call scheduler: latches calls, tracks the car floor from
// motor step pulses, picks travel direction and times the door dwell.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int  N_FLOORS    = N_FLOORS_DEF,
  parameter int  DOOR_CYCLES = 8,
  localparam int FLOOR_W     = $clog2(N_FLOORS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_FLOORS-1:0] car_req_i,
  input  logic [N_FLOORS-1:0] hall_up_req_i,
  input  logic [N_FLOORS-1:0] hall_dn_req_i,
  input  logic                floor_step_i,
  output logic [1:0]          dir_o,
  output logic                door_open_o,
  output logic [FLOOR_W-1:0]  cur_floor_o,
  output logic [N_FLOORS-1:0] pend_car_o,
  output logic [N_FLOORS-1:0] pend_up_o,
  output logic [N_FLOORS-1:0] pend_dn_o
);

  state_e               state_q, state_d;
  dir_e                 last_dir_q, last_dir_d;
  logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
  logic [N_FLOORS-1:0]  pend_car_q, pend_car_d;
  logic [N_FLOORS-1:0]  pend_up_q, pend_up_d;
  logic [N_FLOORS-1:0]  pend_dn_q, pend_dn_d;
  logic [1:0]           dir_q;
  logic                 door_open_q;

  logic [N_FLOORS-1:0]  upValid, dnValid, reqAll, pendAll, clrMask;
  logic [FLOOR_W-1:0]   nfUp, nfDn, fi;
  logic                 anyHere, reqHere, above, below;
  logic                 upHit, dnAtUp, aboveNfUp, dnHit, upAtDn, belowNfDn;
  logic                 stopUp, stopDn, atTop, atBottom;
  logic                 timerLoad, timerDone;

  // The top floor has no up button and the ground floor no down button.
  assign upValid = hall_up_req_i & {1'b0, {(N_FLOORS-1){1'b1}}};
  assign dnValid = hall_dn_req_i & {{(N_FLOORS-1){1'b1}}, 1'b0};
  assign reqAll  = car_req_i | upValid | dnValid;
  assign pendAll = pend_car_q | pend_up_q | pend_dn_q;

  assign nfUp     = cur_floor_q + FLOOR_W'(1);
  assign nfDn     = cur_floor_q - FLOOR_W'(1);
  assign atTop    = (cur_floor_q == FLOOR_W'(N_FLOORS - 1));
  assign atBottom = (cur_floor_q == '0);

  always_comb begin
    anyHere   = 1'b0;
    reqHere   = 1'b0;
    above     = 1'b0;
    below     = 1'b0;
    upHit     = 1'b0;
    dnAtUp    = 1'b0;
    aboveNfUp = 1'b0;
    dnHit     = 1'b0;
    upAtDn    = 1'b0;
    belowNfDn = 1'b0;
    fi        = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      fi = FLOOR_W'(i);
      if (fi == cur_floor_q) begin
        anyHere = pendAll[i];
        reqHere = reqAll[i];
      end
      if (fi > cur_floor_q) above = above | pendAll[i];
      if (fi < cur_floor_q) below = below | pendAll[i];
      if (fi == nfUp) begin
        upHit  = pend_car_q[i] | pend_up_q[i];
        dnAtUp = pend_dn_q[i];
      end
      if (fi > nfUp) aboveNfUp = aboveNfUp | pendAll[i];
      if (fi == nfDn) begin
        dnHit  = pend_car_q[i] | pend_dn_q[i];
        upAtDn = pend_up_q[i];
      end
      if (fi < nfDn) belowNfDn = belowNfDn | pendAll[i];
    end
  end

  // An opposite-direction call only stops the car if it is the last one ahead.
  assign stopUp = upHit | (dnAtUp & ~aboveNfUp);
  assign stopDn = dnHit | (upAtDn & ~belowNfDn);

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    last_dir_d  = last_dir_q;
    timerLoad   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (anyHere) begin
          state_d   = DOOR;
          timerLoad = 1'b1;
        end else if (above && below) begin
          state_d = (last_dir_q == UP) ? MOVE_UP : MOVE_DN;
        end else if (above) begin
          state_d = MOVE_UP;
        end else if (below) begin
          state_d = MOVE_DN;
        end
      end
      MOVE_UP: begin
        if (floor_step_i) begin
          if (atTop) begin
            state_d = IDLE;
          end else begin
            cur_floor_d = nfUp;
            if (stopUp) begin
              state_d   = DOOR;
              timerLoad = 1'b1;
            end
          end
        end
      end
      MOVE_DN: begin
        if (floor_step_i) begin
          if (atBottom) begin
            state_d = IDLE;
          end else begin
            cur_floor_d = nfDn;
            if (stopDn) begin
              state_d   = DOOR;
              timerLoad = 1'b1;
            end
          end
        end
      end
      DOOR: begin
        if (reqHere) begin
          timerLoad = 1'b1;
        end else if (timerDone) begin
          if (last_dir_q == UP) begin
            state_d = above ? MOVE_UP : (below ? MOVE_DN : IDLE);
          end else begin
            state_d = below ? MOVE_DN : (above ? MOVE_UP : IDLE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == MOVE_UP) begin
      last_dir_d = UP;
    end else if (state_d == MOVE_DN) begin
      last_dir_d = DOWN;
    end
  end

  // Calls at the floor where the door is (or is about to be) open are served.
  always_comb begin
    clrMask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if ((state_d == DOOR) && (FLOOR_W'(i) == cur_floor_d)) clrMask[i] = 1'b1;
    end
    pend_car_d = (pend_car_q | car_req_i) & ~clrMask;
    pend_up_d  = (pend_up_q | upValid) & ~clrMask;
    pend_dn_d  = (pend_dn_q | dnValid) & ~clrMask;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_dir_q  <= UP;
      cur_floor_q <= '0;
      pend_car_q  <= '0;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      dir_q       <= STAY;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      cur_floor_q <= cur_floor_d;
      pend_car_q  <= pend_car_d;
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      dir_q       <= dirFor(state_d);
      door_open_q <= (state_d == DOOR);
    end
  end

  lift_door_timer #(
    .CYCLES(DOOR_CYCLES)
  ) u_door_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (timerLoad),
    .en_i   (state_q == DOOR),
    .done_o (timerDone)
  );

  assign dir_o       = dir_q;
  assign door_open_o = door_open_q;
  assign cur_floor_o = cur_floor_q;
  assign pend_car_o  = pend_car_q;
  assign pend_up_o   = pend_up_q;
  assign pend_dn_o   = pend_dn_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: a vector table for the first trip
// plus hand-written sequences for SCAN ordering, door reload and async reset.
module tb_lift_call_scheduler;

  localparam logic [1:0] D_UP = 2'b00;
  localparam logic [1:0] D_DN = 2'b01;
  localparam logic [1:0] D_ST = 2'b10;

  typedef struct packed {
    logic [3:0] car;
    logic [3:0] up;
    logic [3:0] dn;
    logic       step;
    logic [1:0] expDir;
    logic       expDoor;
    logic [1:0] expFloor;
    logic [3:0] expPc;
    logic [3:0] expPu;
    logic [3:0] expPd;
  } vec_t;

  logic       clk;
  logic       rstN;
  logic [3:0] carReq, upReq, dnReq;
  logic       floorStep;
  logic [1:0] dir;
  logic       doorOpen;
  logic [1:0] curFloor;
  logic [3:0] pendCar, pendUp, pendDn;

  int checks = 0;
  int errors = 0;
  vec_t vecs [14];

  lift_call_scheduler #(
    .N_FLOORS    (4),
    .DOOR_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .car_req_i     (carReq),
    .hall_up_req_i (upReq),
    .hall_dn_req_i (dnReq),
    .floor_step_i  (floorStep),
    .dir_o         (dir),
    .door_open_o   (doorOpen),
    .cur_floor_o   (curFloor),
    .pend_car_o    (pendCar),
    .pend_up_o     (pendUp),
    .pend_dn_o     (pendDn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] c, input logic [3:0] u,
                               input logic [3:0] d, input logic s);
    carReq    = c;
    upReq     = u;
    dnReq     = d;
    floorStep = s;
    @(posedge clk);
    #1;
    carReq    = '0;
    upReq     = '0;
    dnReq     = '0;
    floorStep = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eDir,
                             input logic eDoor, input logic [1:0] eFloor,
                             input logic [3:0] ePc, input logic [3:0] ePu,
                             input logic [3:0] ePd);
    checks++;
    if ({dir, doorOpen, curFloor, pendCar, pendUp, pendDn} !==
        {eDir, eDoor, eFloor, ePc, ePu, ePd}) begin
      errors++;
      $display("[TB] FAIL %s: got dir=%b door=%b floor=%0d pc=%b pu=%b pd=%b, want dir=%b door=%b floor=%0d pc=%b pu=%b pd=%b",
               name, dir, doorOpen, curFloor, pendCar, pendUp, pendDn,
               eDir, eDoor, eFloor, ePc, ePu, ePd);
    end
  endtask

  task automatic dwell(input int n, input logic [1:0] fl, input logic [3:0] pc,
                       input logic [3:0] pu, input logic [3:0] pd);
    for (int k = 0; k < n; k++) begin
      applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
      checkOutput($sformatf("dwell f%0d c%0d", fl, k), D_ST, 1'b1, fl, pc, pu, pd);
    end
  endtask

  initial begin
    // First trip: ground floor to floor 2 and a full door dwell.
    vecs[0]  = '{4'h0, 4'h0, 4'h0, 1'b1, D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'h4, 4'h0, 4'h0, 1'b0, D_ST, 1'b0, 2'd0, 4'h4, 4'h0, 4'h0};
    vecs[2]  = '{4'h0, 4'h0, 4'h0, 1'b0, D_UP, 1'b0, 2'd0, 4'h4, 4'h0, 4'h0};
    vecs[3]  = '{4'h0, 4'h0, 4'h0, 1'b1, D_UP, 1'b0, 2'd1, 4'h4, 4'h0, 4'h0};
    vecs[4]  = '{4'h0, 4'h0, 4'h0, 1'b0, D_UP, 1'b0, 2'd1, 4'h4, 4'h0, 4'h0};
    vecs[5]  = '{4'h0, 4'h0, 4'h0, 1'b1, D_ST, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0};
    for (int k = 6; k <= 12; k++)
      vecs[k] = '{4'h0, 4'h0, 4'h0, 1'b0, D_ST, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0};
    vecs[13] = '{4'h0, 4'h0, 4'h0, 1'b0, D_ST, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0};

    rstN      = 1'b0;
    carReq    = '0;
    upReq     = '0;
    dnReq     = '0;
    floorStep = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    rstN = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("idle step ignored", D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].car, vecs[v].up, vecs[v].dn, vecs[v].step);
      checkOutput($sformatf("vec%0d", v), vecs[v].expDir, vecs[v].expDoor,
                  vecs[v].expFloor, vecs[v].expPc, vecs[v].expPu, vecs[v].expPd);
    end

    // Invalid hall buttons (up at top, down at ground) never latch.
    applyStimulus(4'h0, 4'h8, 4'h1, 1'b0);
    checkOutput("invalid hall bits", D_ST, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("invalid hall idle", D_ST, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0);

    // Move down to floor 1.
    applyStimulus(4'h2, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 car1 latch", D_ST, 1'b0, 2'd2, 4'h2, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 start down", D_DN, 1'b0, 2'd2, 4'h2, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s3 door f1", D_ST, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    dwell(7, 2'd1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 idle f1", D_ST, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0);

    // Down call at 2 is passed while a car call at 3 remains above.
    applyStimulus(4'h8, 4'h0, 4'h4, 1'b0);
    checkOutput("s3 calls latch", D_ST, 1'b0, 2'd1, 4'h8, 4'h0, 4'h4);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 start up", D_UP, 1'b0, 2'd1, 4'h8, 4'h0, 4'h4);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s3 pass f2", D_UP, 1'b0, 2'd2, 4'h8, 4'h0, 4'h4);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s3 door f3", D_ST, 1'b1, 2'd3, 4'h0, 4'h0, 4'h4);
    dwell(7, 2'd3, 4'h0, 4'h0, 4'h4);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 reverse", D_DN, 1'b0, 2'd3, 4'h0, 4'h0, 4'h4);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s3 door f2", D_ST, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    dwell(7, 2'd2, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s3 idle f2", D_ST, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0);

    // Back to floor 1 going down, then calls on both sides.
    applyStimulus(4'h2, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 car1 latch", D_ST, 1'b0, 2'd2, 4'h2, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 start down", D_DN, 1'b0, 2'd2, 4'h2, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s4 door f1", D_ST, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
    dwell(7, 2'd1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 idle f1", D_ST, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h8, 4'h1, 4'h0, 1'b0);
    checkOutput("s4 calls latch", D_ST, 1'b0, 2'd1, 4'h8, 4'h1, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 keep down", D_DN, 1'b0, 2'd1, 4'h8, 4'h1, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s4 door f0", D_ST, 1'b1, 2'd0, 4'h8, 4'h0, 4'h0);
    dwell(7, 2'd0, 4'h8, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 reverse up", D_UP, 1'b0, 2'd0, 4'h8, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s4 pass f1", D_UP, 1'b0, 2'd1, 4'h8, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s4 pass f2", D_UP, 1'b0, 2'd2, 4'h8, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s4 door f3", D_ST, 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
    dwell(7, 2'd3, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s4 idle f3", D_ST, 1'b0, 2'd3, 4'h0, 4'h0, 4'h0);

    // Door reload: request at the open floor when the timer reads 1.
    applyStimulus(4'h4, 4'h0, 4'h0, 1'b0);
    checkOutput("s5 car2 latch", D_ST, 1'b0, 2'd3, 4'h4, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s5 start down", D_DN, 1'b0, 2'd3, 4'h4, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s5 door f2", D_ST, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    dwell(6, 2'd2, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h4, 4'h0, 4'h0, 1'b0);
    checkOutput("s5 reload absorbed", D_ST, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0);
    dwell(7, 2'd2, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s5 door closes", D_ST, 1'b0, 2'd2, 4'h0, 4'h0, 4'h0);

    // Asynchronous reset while moving up from floor 2.
    applyStimulus(4'h8, 4'h0, 4'h0, 1'b0);
    checkOutput("s6 car3 latch", D_ST, 1'b0, 2'd2, 4'h8, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s6 moving up", D_UP, 1'b0, 2'd2, 4'h8, 4'h0, 4'h0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("s6 async reset", D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("s6 post reset", D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("s6 stays idle", D_ST, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
